// File: rtl/ref_win_loader.sv
`default_nettype none
// ============================================================================
// Module   : ref_win_loader
// Brief    : Writer side of the half-pel interpolator window interface.
//            Streams a WIN_W x WIN_W raster window into win_flat, latches the
//            centre index, runs the interpolator and returns its 9 half-pel
//            and 4 half_pix outputs on a valid/ready result port.
// Config   : CENTRE_CLAMP_EN - clamp the centre row/col into 3..12 so the
//            6-tap support stays inside the window, and flag range_err.
// Revision : 1.0 - initial release
// ============================================================================
module ref_win_loader #(
    parameter int TIMEOUT_CYC = 64,
    parameter int WIN_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               pix_in,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [7:0]               centre_in,
    output logic [8*WIN_W*WIN_W-1:0] win_flat,
    output logic                     ip_rst_n,
    output logic [7:0]               ip_centre,
    input  logic                     ip_done,
    input  logic [71:0]              ip_half,
    input  logic [31:0]              ip_half_pix,
    output logic [71:0]              res_half,
    output logic [31:0]              res_half_pix,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     timeout_err,
    output logic                     range_err,
    output logic                     busy
);

    localparam int C_DEPTH = WIN_W * WIN_W;
    localparam int C_CW    = $clog2(C_DEPTH);
    localparam int C_WW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [C_CW-1:0] C_LAST_IDX  = C_CW'(C_DEPTH - 1);
    localparam logic [C_WW-1:0] C_WAIT_LAST = C_WW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [C_CW-1:0]          wr_cnt_q, wr_cnt_d;
    logic [C_WW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [8*C_DEPTH-1:0]     win_flat_q, win_flat_d;
    logic [7:0]               ip_centre_q, ip_centre_d;
    logic [71:0]              res_half_q, res_half_d;
    logic [31:0]              res_half_pix_q, res_half_pix_d;
    logic                     res_valid_q, res_valid_d;
    logic                     timeout_err_q, timeout_err_d;
    logic                     range_err_q, range_err_d;
    logic                     clamp_hit_q, clamp_hit_d;
    logic                     pix_ready_q, pix_ready_d;
    logic                     ip_rst_n_q, ip_rst_n_d;

    logic                     pix_acc;
    logic [C_CW-1:0]          wr_idx;
    logic [7:0]               centre_lat;
    logic                     centre_oor;

    assign pix_acc = pix_valid && pix_ready_q;
    // The first pixel of a load always lands in byte 0
    assign wr_idx  = (state_q == S_IDLE) ? '0 : wr_cnt_q;

`ifdef CENTRE_CLAMP_EN
    localparam logic [3:0] C_CLAMP_LO = 4'd3;
    localparam logic [3:0] C_CLAMP_HI = 4'(WIN_W - 4);

    logic [3:0] row_c, col_c;

    // Pull each coordinate into the region where the 6-tap support fits
    always_comb begin
        row_c      = centre_in[7:4];
        col_c      = centre_in[3:0];
        centre_oor = 1'b0;
        if (centre_in[7:4] < C_CLAMP_LO) begin
            row_c      = C_CLAMP_LO;
            centre_oor = 1'b1;
        end else if (centre_in[7:4] > C_CLAMP_HI) begin
            row_c      = C_CLAMP_HI;
            centre_oor = 1'b1;
        end
        if (centre_in[3:0] < C_CLAMP_LO) begin
            col_c      = C_CLAMP_LO;
            centre_oor = 1'b1;
        end else if (centre_in[3:0] > C_CLAMP_HI) begin
            col_c      = C_CLAMP_HI;
            centre_oor = 1'b1;
        end
        centre_lat = {row_c, col_c};
    end
`else
    // Centre passes through; with no clamp flag range_err stays at 0
    assign centre_lat = centre_in;
    assign centre_oor = 1'b0;
`endif

    // Next-state and datapath updates for the load / run / return sequence
    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        win_flat_d     = win_flat_q;
        ip_centre_d    = ip_centre_q;
        res_half_d     = res_half_q;
        res_half_pix_d = res_half_pix_q;
        res_valid_d    = res_valid_q;
        timeout_err_d  = timeout_err_q;
        range_err_d    = range_err_q;
        clamp_hit_d    = clamp_hit_q;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (pix_acc) begin
                    win_flat_d[{wr_idx, 3'b000} +: 8] = pix_in;
                    if (wr_idx == C_LAST_IDX) begin
                        wr_cnt_d    = '0;
                        wait_cnt_d  = '0;
                        ip_centre_d = centre_lat;
                        clamp_hit_d = centre_oor;
                        state_d     = S_WAIT;
                    end else begin
                        wr_cnt_d = wr_idx + C_CW'(1);
                        state_d  = S_LOAD;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + C_WW'(1);
                // A done flag wins over a timeout landing in the same cycle
                if (ip_done) begin
                    res_half_d     = ip_half;
                    res_half_pix_d = ip_half_pix;
                    res_valid_d    = 1'b1;
                    range_err_d    = clamp_hit_q;
                    state_d        = S_OUT;
                end else if (wait_cnt_q == C_WAIT_LAST) begin
                    res_half_d     = '0;
                    res_half_pix_d = '0;
                    res_valid_d    = 1'b1;
                    timeout_err_d  = 1'b1;
                    range_err_d    = clamp_hit_q;
                    state_d        = S_OUT;
                end
            end
            S_OUT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d   = 1'b0;
                    timeout_err_d = 1'b0;
                    range_err_d   = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake and interpolator reset are registered from the next state
        pix_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        ip_rst_n_d  = (state_d == S_WAIT);
    end

    // State register; reset discards any partial load or pending run
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wr_cnt_q       <= '0;
            wait_cnt_q     <= '0;
            win_flat_q     <= '0;
            ip_centre_q    <= '0;
            res_half_q     <= '0;
            res_half_pix_q <= '0;
            res_valid_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            range_err_q    <= 1'b0;
            clamp_hit_q    <= 1'b0;
            pix_ready_q    <= 1'b0;
            ip_rst_n_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            win_flat_q     <= win_flat_d;
            ip_centre_q    <= ip_centre_d;
            res_half_q     <= res_half_d;
            res_half_pix_q <= res_half_pix_d;
            res_valid_q    <= res_valid_d;
            timeout_err_q  <= timeout_err_d;
            range_err_q    <= range_err_d;
            clamp_hit_q    <= clamp_hit_d;
            pix_ready_q    <= pix_ready_d;
            ip_rst_n_q     <= ip_rst_n_d;
        end
    end

    assign pix_ready    = pix_ready_q;
    assign win_flat     = win_flat_q;
    assign ip_rst_n     = ip_rst_n_q;
    assign ip_centre    = ip_centre_q;
    assign res_half     = res_half_q;
    assign res_half_pix = res_half_pix_q;
    assign res_valid    = res_valid_q;
    assign timeout_err  = timeout_err_q;
    assign range_err    = range_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire
